// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bus bundle: instruction-memory handshake, redirect and decode-side queue head.
// master = fetch unit, slave = the surroundings (memory, redirect source, decode).
interface fetch_queue_unit_if #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               halted;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, halted,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, halted,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch front end. Issues req/ack fetches to instruction memory,
// buffers {instr, pc} pairs in a DEPTH-entry circular queue and hands them to decode over
// valid/ready. A redirect flushes the queue and restarts fetch at a new PC.
// Optional macro FETCH_HALT_EN: stop fetching once an opcode-4'hF instruction is queued.
module fetch_queue_unit #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    fetch_queue_unit_if.master bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic               halted_q, halted_d;
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [CntW-1:0]    count_after;
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [PC_W-1:0]    pc_q [DEPTH];

    logic head_valid;
    logic push;
    logic pop;
    logic halt_hit;

    assign head_valid = (count_q != '0);
    // A redirect flushes the queue, so a coincident pop must not move rd_ptr.
    assign pop        = head_valid & bus.out_ready & ~bus.redirect_valid;

`ifdef FETCH_HALT_EN
    assign halt_hit = (bus.imem_rdata[INSTR_W-1 -: 4] == 4'hF);
`else
    assign halt_hit = 1'b0;
`endif

    // Fetch FSM: request issue under the credit rule, back-to-back refetch, stale-ack drop.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        fetch_pc_d  = fetch_pc_q;
        halted_d    = halted_q;
        push        = 1'b0;
        count_after = count_q;
        case (state_q)
            StIdle: begin
                if (!bus.redirect_valid && !halted_q && (count_q < Full)) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.imem_ack) begin
                    if (bus.redirect_valid) begin
                        req_d   = 1'b0;
                        state_d = StIdle;
                    end else begin
                        push        = 1'b1;
                        fetch_pc_d  = addr_q + 1'b1;
                        count_after = count_q + CntW'(1) - CntW'(pop);
                        // Next request needs a free slot after this push/pop settles.
                        if (!halt_hit && (count_after < Full)) begin
                            addr_d = addr_q + 1'b1;
                        end else begin
                            req_d   = 1'b0;
                            state_d = StIdle;
                        end
                    end
                end else if (bus.redirect_valid) begin
                    // An unacked request cannot be withdrawn; wait out its ack.
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (bus.imem_ack) begin
                    req_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
        if (push && halt_hit) begin
            halted_d = 1'b1;
        end
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            halted_d   = 1'b0;
        end
    end

    // Queue pointer and occupancy next-state; redirect empties the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Control and pointer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            addr_q     <= PC_W'(RESET_PC);
            fetch_pc_q <= PC_W'(RESET_PC);
            halted_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            halted_q   <= halted_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage: write the acked instruction tagged with the address it was fetched from.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (push) begin
            instr_q[wr_ptr_q] <= bus.imem_rdata;
            pc_q[wr_ptr_q]    <= addr_q;
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.out_valid = head_valid;
    assign bus.out_instr = instr_q[rd_ptr_q];
    assign bus.out_pc    = pc_q[rd_ptr_q];
    assign bus.halted    = halted_q;
endmodule
